ctrl_fsm_ac1: RTL

Sequencer that drives the AC1 accumulator register on the SMAC datapath. It accepts a start command and then handshakes N partial products from the multiplier stage, with N = Pa in 8-bit mode and Pa/2 in 4-bit mode. For each accepted product it issues one load or accumulate strobe to AC1, then holds the finished result valid until the downstream stage acknowledges it. It is the issuing side of the AC1 sample-count/terminate protocol: it generates the sample strobes that the AC1 sample counter consumes.

---
 rtl/ctrl_fsm_ac1_if.sv | 30 +++
 rtl/ctrl_fsm_ac1.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ctrl_fsm_ac1_if.sv
// Purpose: groups the AC1 sequencer command, partial-product handshake,
//          AC1 strobe and result handshake signals into one bundle.
// Ports:   master = sequencer side (drives pp_ready, strobes, status);
//          slave  = environment side (drives start/mode/abort/pp_valid/res_ack).
interface ctrl_fsm_ac1_if #(
    parameter int Pa = 8
);
    logic                  start;
    logic                  par_sel_Pa;
    logic                  abort;
    logic                  pp_valid;
    logic                  pp_ready;
    logic                  ac1_load;
    logic                  ac1_en;
    logic                  ac1_last;
    logic [$clog2(Pa):0]   sample_idx;
    logic                  res_valid;
    logic                  res_ack;
    logic                  busy;

    modport master (
        input  start, par_sel_Pa, abort, pp_valid, res_ack,
        output pp_ready, ac1_load, ac1_en, ac1_last, sample_idx, res_valid, busy
    );

    modport slave (
        output start, par_sel_Pa, abort, pp_valid, res_ack,
        input  pp_ready, ac1_load, ac1_en, ac1_last, sample_idx, res_valid, busy
    );
endinterface

// File: rtl/ctrl_fsm_ac1.sv
// Purpose: sequences N partial products into AC1 (1 load + N-1 accumulates),
//          then holds res_valid until res_ack. N = Pa (8-bit) or Pa/2 (4-bit).
// Latency: start at edge k -> strobes in k+1..k+N with pp_valid high, res_valid at k+N+1.
// Backpressure: pp_valid low stalls without strobes; res_valid held until res_ack.
// Ports: clk, rst_n (async active-low), bus (ctrl_fsm_ac1_if.master).
// Option: define AC1_B2B_EN to allow res_ack & start in DONE to go straight to LOAD.
module ctrl_fsm_ac1 #(
    parameter int Pa = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ctrl_fsm_ac1_if.master       bus
);
    localparam int IW = $clog2(Pa) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_mode;
    logic            w_mode_nxt;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nxt;
    logic [IW-1:0]   w_n;
    logic            w_pp_ready;
    logic            w_load;
    logic            w_en;
    logic            w_last;

    // Product count for the result in flight, from the mode latched at start.
    assign w_n = r_mode ? IW'(Pa) : IW'(Pa / 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b1;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_en        = 1'b0;
        w_last      = 1'b0;
        // abort is the only input allowed into pp_ready: it must not offer
        // a handshake in the cycle it cancels the result.
        w_pp_ready  = ((r_state == S_LOAD) || (r_state == S_ACC)) && !bus.abort;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_LOAD;
                    w_mode_nxt  = bus.par_sel_Pa;
                    w_idx_nxt   = '0;
                end
            end
            S_LOAD: begin
                if (bus.pp_valid) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = IW'(1);
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                if (bus.pp_valid) begin
                    w_en      = 1'b1;
                    w_idx_nxt = r_idx + IW'(1);
                    if (r_idx == w_n - IW'(1)) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.res_ack) begin
`ifdef AC1_B2B_EN
                    if (bus.start) begin
                        w_state_nxt = S_LOAD;
                        w_mode_nxt  = bus.par_sel_Pa;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Cancel wins over everything, including start and res_ack.
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
            w_mode_nxt  = r_mode;
            w_idx_nxt   = '0;
            w_load      = 1'b0;
            w_en        = 1'b0;
            w_last      = 1'b0;
        end
    end

    assign bus.pp_ready   = w_pp_ready;
    assign bus.ac1_load   = w_load;
    assign bus.ac1_en     = w_en;
    assign bus.ac1_last   = w_last;
    assign bus.sample_idx = r_idx;
    assign bus.res_valid  = (r_state == S_DONE);
    assign bus.busy       = (r_state != S_IDLE);
endmodule
